// File: rtl/register_file_32x32.sv
// MIPS general-purpose register file: 32 x WIDTH registers, two combinational read ports and
// one clocked write port. r0 is hardwired to zero and has no storage; r28 ($gp) and r29 ($sp)
// reset to non-zero values. Reset is synchronous and active-high.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset; wins over a same-edge write
//   reg_write   write enable for this cycle
//   write_addr  destination register index
//   write_data  writeback data
//   read_addr1  read port 1 index (rs)
//   read_addr2  read port 2 index (rt)
//   read_data1  read port 1 data, combinational
//   read_data2  read port 2 data, combinational
module register_file_32x32 #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h7FFF_FFFC,
  parameter logic [WIDTH-1:0] GP_INIT = 32'h1000_8000,
  parameter bit               BYPASS  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [4:0]       write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [4:0]       read_addr1,
  input  logic [4:0]       read_addr2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  // Storage only for r1..r31; r0 is a constant in the read view below.
  logic [WIDTH-1:0] regs_q [1:31];
  logic [WIDTH-1:0] regs_d [1:31];
  logic [WIDTH-1:0] rf_view [32];

  // One-hot write select, already qualified by reg_write. Address 0 has no select bit, so
  // writes to r0 fall away naturally.
  logic [31:1] sel;

  always_comb begin
    sel = '0;
    for (int i = 1; i < 32; i++) begin
      sel[i] = reg_write && (write_addr == 5'(i));
    end
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = sel[i] ? write_data : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        if (i == 28) begin
          regs_q[i] <= GP_INIT;
        end else if (i == 29) begin
          regs_q[i] <= SP_INIT;
        end else begin
          regs_q[i] <= '0;
        end
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  // Forwarding is only legal when the write will actually land: not during reset and never
  // for r0.
  logic fwd1, fwd2;

  always_comb begin
    fwd1 = BYPASS && !reset && reg_write && (write_addr == read_addr1) && (read_addr1 != 5'd0);
    fwd2 = BYPASS && !reset && reg_write && (write_addr == read_addr2) && (read_addr2 != 5'd0);
  end

  always_comb begin
    read_data1 = fwd1 ? write_data : rf_view[read_addr1];
    read_data2 = fwd2 ? write_data : rf_view[read_addr2];
  end

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed bench for register_file_32x32. Two instances share all inputs: u_nobyp (BYPASS=0)
// and u_byp (BYPASS=1), so both forwarding configurations are exercised by one stimulus.
module tb_register_file_32x32;

  localparam logic [31:0] SpInit = 32'h7FFF_FFFC;
  localparam logic [31:0] GpInit = 32'h1000_8000;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] rd1_nb, rd2_nb, rd1_b, rd2_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_rf [32];

  register_file_32x32 #(
    .WIDTH  (32),
    .SP_INIT(SpInit),
    .GP_INIT(GpInit),
    .BYPASS (1'b0)
  ) u_nobyp (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_addr1(read_addr1),
    .read_addr2(read_addr2),
    .read_data1(rd1_nb),
    .read_data2(rd2_nb)
  );

  register_file_32x32 #(
    .WIDTH  (32),
    .SP_INIT(SpInit),
    .GP_INIT(GpInit),
    .BYPASS (1'b1)
  ) u_byp (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .write_addr(write_addr),
    .write_data(write_data),
    .read_addr1(read_addr1),
    .read_addr2(read_addr2),
    .read_data1(rd1_b),
    .read_data2(rd2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Point both ports somewhere, settle, and check all four outputs against exp1/exp2.
  task automatic read_pair(input string tag, input logic [4:0] a, input logic [4:0] b,
                           input logic [31:0] exp1, input logic [31:0] exp2);
    read_addr1 = a;
    read_addr2 = b;
    #1;
    check_eq({tag, " nb p1"}, rd1_nb, exp1);
    check_eq({tag, " nb p2"}, rd2_nb, exp2);
    check_eq({tag, " b p1"},  rd1_b,  exp1);
    check_eq({tag, " b p2"},  rd2_b,  exp2);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_addr = a;
    write_data = d;
    step();
    reg_write  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_addr1 = '0;
    read_addr2 = '0;

    // Reset contents.
    step();
    reset = 1'b0;
    read_pair("rst r0/r28", 5'd0, 5'd28, 32'h0, GpInit);
    read_pair("rst r29/r5", 5'd29, 5'd5, SpInit, 32'h0);

    // Basic write.
    write_reg(5'd5, 32'hDEAD_BEEF);
    read_pair("wr r5/r6", 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h0);

    // r0 stays zero.
    write_reg(5'd0, 32'hFFFF_FFFF);
    read_pair("r0 prot", 5'd0, 5'd0, 32'h0, 32'h0);

    // Same-cycle hazard on r7.
    write_reg(5'd7, 32'h1111_1111);
    reg_write  = 1'b1;
    write_addr = 5'd7;
    write_data = 32'h2222_2222;
    read_addr1 = 5'd0;
    read_addr2 = 5'd7;
    #1;
    check_eq("haz nb p2", rd2_nb, 32'h1111_1111);
    check_eq("haz b p2",  rd2_b,  32'h2222_2222);
    check_eq("haz b p1 r0", rd1_b, 32'h0);
    step();
    reg_write = 1'b0;
    read_pair("haz after", 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222);

    // Reset beats a same-edge write; forwarding is suppressed while reset is high.
    write_reg(5'd9, 32'hA5A5_A5A5);
    reset      = 1'b1;
    reg_write  = 1'b1;
    write_addr = 5'd9;
    write_data = 32'h1234_5678;
    read_addr1 = 5'd9;
    read_addr2 = 5'd9;
    #1;
    check_eq("rstfwd nb", rd1_nb, 32'hA5A5_A5A5);
    check_eq("rstfwd b",  rd1_b,  32'hA5A5_A5A5);
    step();
    reset     = 1'b0;
    reg_write = 1'b0;
    read_pair("rstpri r9/r29", 5'd9, 5'd29, 32'h0, SpInit);
    read_pair("rstpri r5/r7", 5'd5, 5'd7, 32'h0, 32'h0);

    // Sweep: fill r1..r31, then idle cycles with junk on the write bus.
    exp_rf[0] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      exp_rf[i] = 32'h0101_0101 * 32'(i);
      write_reg(5'(i), exp_rf[i]);
    end
    for (int k = 0; k < 24; k++) begin
      reg_write  = 1'b0;
      write_addr = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_addr1 = write_addr;
      read_addr2 = write_addr;
      #1;
      check_eq("idle nofwd b", rd1_b, exp_rf[write_addr]);
      step();
    end
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        read_pair("sweep", 5'(a), 5'(b), exp_rf[a], exp_rf[b]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
